// File: rtl/axis_flow_checker_pkg.sv
// Shared definitions for the AXI-Stream flow checker: error codes, FSM states, header byte offsets.
// Pure declarations; no latency or backpressure of its own.
package axis_flow_checker_pkg;

  localparam logic [2:0] ERR_NONE     = 3'd0;
  localparam logic [2:0] ERR_BAD_LEN  = 3'd1;
  localparam logic [2:0] ERR_BAD_KEEP = 3'd2;
  localparam logic [2:0] ERR_BAD_DATA = 3'd3;
  localparam logic [2:0] ERR_SHORT    = 3'd4;
  localparam logic [2:0] ERR_LONG     = 3'd5;
  localparam logic [2:0] ERR_BAD_FLOW = 3'd6;
  localparam logic [2:0] ERR_BAD_SEQ  = 3'd7;

  localparam int LEN_HI = 16;
  localparam int LEN_LO = 17;
  localparam int FLOW   = 35;

  typedef enum logic [1:0] {
    ST_HDR     = 2'd0,
    ST_PAYLOAD = 2'd1,
    ST_DRAIN   = 2'd2
  } state_t;

  // Lowest-numbered raised flag wins when one beat trips several checks.
  function automatic logic [2:0] first_err(input logic [7:1] flags);
    logic [2:0] code;
    code = ERR_NONE;
    for (int i = 7; i >= 1; i--) begin
      if (flags[i]) code = 3'(i);
    end
    return code;
  endfunction

endpackage

// File: rtl/flow_stat_bank.sv
// Per-flow good-packet counters with an increment strobe and a registered select-read port.
// Read data is one cycle after sel or increment; no backpressure.
module flow_stat_bank #(
  parameter int NUM_FLOWS = 4,
  parameter int CNT_WIDTH = 32,
  localparam int IDX_WIDTH = $clog2(NUM_FLOWS)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [IDX_WIDTH-1:0] inc_idx,
  input  logic                 inc_en,
  input  logic [IDX_WIDTH-1:0] rd_sel,
  output logic [CNT_WIDTH-1:0] rd_data
);

  logic [CNT_WIDTH-1:0] cnt [NUM_FLOWS];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_FLOWS; i++) cnt[i] <= '0;
      rd_data <= '0;
    end else begin
      if (inc_en) cnt[inc_idx] <= cnt[inc_idx] + CNT_WIDTH'(1);
      // Bypass a same-cycle increment so the read port shows it with the other counters.
      rd_data <= (inc_en && (inc_idx == rd_sel)) ? cnt[rd_sel] + CNT_WIDTH'(1) : cnt[rd_sel];
    end
  end

endmodule

// File: rtl/axis_flow_checker.sv
// AXI-Stream sink checking fixed-size UDP test packets (length, beats, tkeep, payload sequence) with stats.
// Errors, pulses and counters appear one cycle after the accepting edge; tready is enable delayed one cycle.
module axis_flow_checker
  import axis_flow_checker_pkg::*;
#(
  parameter int DATA_WIDTH     = 512,
  parameter int KEEP_WIDTH     = DATA_WIDTH / 8,
  parameter int PKT_BEATS      = 23,
  parameter int FLOW_ID_WIDTH  = 5,
  parameter int NUM_FLOWS      = 4,
  parameter int CNT_WIDTH      = 32,
  parameter int BYTE_CNT_WIDTH = 64,
  localparam int SEL_WIDTH     = $clog2(NUM_FLOWS)
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [DATA_WIDTH-1:0]     s_axis_tdata,
  input  logic [KEEP_WIDTH-1:0]     s_axis_tkeep,
  input  logic                      s_axis_tvalid,
  output logic                      s_axis_tready,
  input  logic                      s_axis_tlast,
  input  logic                      enable,
  input  logic [SEL_WIDTH-1:0]      stat_flow_sel,
  output logic [CNT_WIDTH-1:0]      stat_flow_pkts,
  output logic [CNT_WIDTH-1:0]      stat_total_pkts,
  output logic [BYTE_CNT_WIDTH-1:0] stat_total_bytes,
  output logic [CNT_WIDTH-1:0]      stat_err_count,
  output logic                      pkt_done,
  output logic                      err_valid,
  output logic [2:0]                err_code,
  output logic [FLOW_ID_WIDTH-1:0]  err_flow
);

  localparam int BW = $clog2(PKT_BEATS + 1);
  localparam logic [15:0]              EXP_LEN    = 16'(PKT_BEATS * 64 - 14);
  localparam logic [BW-1:0]            LAST_IDX   = BW'(PKT_BEATS - 1);
  localparam logic [FLOW_ID_WIDTH:0]   FLOW_LIMIT = (FLOW_ID_WIDTH + 1)'(NUM_FLOWS);

  state_t                   state, state_nxt;
  logic [BW-1:0]            beat_idx, beat_idx_nxt;
  logic [63:0]              base, base_nxt;
  logic [63:0]              prev_base;
  logic                     prev_vld;
  logic [FLOW_ID_WIDTH-1:0] flow_id, flow_nxt, cur_flow;
  logic                     err_seen;
  logic [7:1]               flags;
  logic                     done;
  logic                     accept;
  logic                     any_flag;
  logic                     new_err;
  logic                     pkt_good;

  logic [FLOW_ID_WIDTH-1:0] hdr_flow;
  logic [15:0]              hdr_len;
  logic [63:0]              beat_word;
  logic [DATA_WIDTH-1:0]    exp_data;
  logic                     keep_bad;

  assign accept    = s_axis_tvalid && s_axis_tready;
  assign hdr_flow  = s_axis_tdata[FLOW*8 +: FLOW_ID_WIDTH];
  assign hdr_len   = {s_axis_tdata[LEN_HI*8 +: 8], s_axis_tdata[LEN_LO*8 +: 8]};
  assign beat_word = s_axis_tdata[63:0];
  assign exp_data  = DATA_WIDTH'(base + 64'(beat_idx));
  assign keep_bad  = s_axis_tkeep != '1;

  always_comb begin
    state_nxt    = state;
    beat_idx_nxt = beat_idx;
    base_nxt     = base;
    flow_nxt     = flow_id;
    cur_flow     = flow_id;
    flags        = '0;
    done         = 1'b0;
    if (accept) begin
      case (state)
        ST_HDR: begin
          cur_flow                 = hdr_flow;
          flow_nxt                 = hdr_flow;
          flags[ERR_BAD_LEN]       = hdr_len != EXP_LEN;
          flags[ERR_BAD_KEEP]      = keep_bad;
          flags[ERR_BAD_FLOW]      = {1'b0, hdr_flow} >= FLOW_LIMIT;
          if (s_axis_tlast) begin
            flags[ERR_SHORT] = 1'b1;
            done             = 1'b1;
          end else begin
            state_nxt    = ST_PAYLOAD;
            beat_idx_nxt = BW'(1);
          end
        end
        ST_PAYLOAD: begin
          flags[ERR_BAD_KEEP] = keep_bad;
          if (beat_idx == BW'(1)) begin
            base_nxt           = beat_word - 64'd1;
            flags[ERR_BAD_SEQ] = prev_vld && ((beat_word - 64'd1) != (prev_base + 64'd1));
          end else begin
            flags[ERR_BAD_DATA] = s_axis_tdata != exp_data;
          end
          beat_idx_nxt = beat_idx + BW'(1);
          if (s_axis_tlast) begin
            flags[ERR_SHORT] = beat_idx != LAST_IDX;
            done             = 1'b1;
            state_nxt        = ST_HDR;
          end else if (beat_idx == LAST_IDX) begin
            flags[ERR_LONG] = 1'b1;
            state_nxt       = ST_DRAIN;
          end
        end
        ST_DRAIN: begin
          if (s_axis_tlast) begin
            done      = 1'b1;
            state_nxt = ST_HDR;
          end
        end
        default: state_nxt = ST_HDR;
      endcase
    end
  end

  assign any_flag = |flags;
  assign new_err  = any_flag && !err_seen;
  assign pkt_good = done && !err_seen && !any_flag;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state            <= ST_HDR;
      beat_idx         <= '0;
      base             <= '0;
      prev_base        <= '0;
      prev_vld         <= 1'b0;
      flow_id          <= '0;
      err_seen         <= 1'b0;
      s_axis_tready    <= 1'b0;
      pkt_done         <= 1'b0;
      err_valid        <= 1'b0;
      err_code         <= ERR_NONE;
      err_flow         <= '0;
      stat_total_pkts  <= '0;
      stat_total_bytes <= '0;
      stat_err_count   <= '0;
    end else begin
      state         <= state_nxt;
      beat_idx      <= beat_idx_nxt;
      base          <= base_nxt;
      flow_id       <= flow_nxt;
      err_seen      <= done ? 1'b0 : (err_seen | any_flag);
      s_axis_tready <= enable;
      pkt_done      <= done;
      err_valid     <= new_err;
      err_code      <= new_err ? first_err(flags) : ERR_NONE;
      err_flow      <= new_err ? cur_flow : '0;
      if (done) stat_total_pkts <= stat_total_pkts + CNT_WIDTH'(1);
      if (done && !pkt_good) stat_err_count <= stat_err_count + CNT_WIDTH'(1);
      if (accept) stat_total_bytes <= stat_total_bytes + BYTE_CNT_WIDTH'(KEEP_WIDTH);
      if (pkt_good) begin
        prev_base <= base_nxt;
        prev_vld  <= 1'b1;
      end
    end
  end

  flow_stat_bank #(
    .NUM_FLOWS (NUM_FLOWS),
    .CNT_WIDTH (CNT_WIDTH)
  ) u_flow_stat_bank (
    .clk     (clk),
    .rst_n   (rst_n),
    .inc_idx (cur_flow[SEL_WIDTH-1:0]),
    .inc_en  (pkt_good),
    .rd_sel  (stat_flow_sel),
    .rd_data (stat_flow_pkts)
  );

endmodule

// File: tb/tb_axis_flow_checker.sv
// Directed bench for axis_flow_checker: clean traffic, each error class, backpressure and resets.
module tb_axis_flow_checker;

  localparam int DW  = 512;
  localparam int KW  = 64;
  localparam int PB  = 23;
  localparam int FW  = 5;
  localparam int NF  = 4;
  localparam int CW  = 32;
  localparam int BCW = 64;
  localparam int GOOD_LEN = 1458;  // 23*64-14
  localparam int LIMIT    = 200;
  localparam int FLOWS    [10] = '{0, 1, 2, 0, 1, 1, 0, 1, 2, 1};
  localparam int EXP_FLOW [4]  = '{6, 10, 4, 0};

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic           rst_n;
  logic [DW-1:0]  s_axis_tdata;
  logic [KW-1:0]  s_axis_tkeep;
  logic           s_axis_tvalid;
  logic           s_axis_tready;
  logic           s_axis_tlast;
  logic           enable;
  logic [1:0]     stat_flow_sel;
  logic [CW-1:0]  stat_flow_pkts;
  logic [CW-1:0]  stat_total_pkts;
  logic [BCW-1:0] stat_total_bytes;
  logic [CW-1:0]  stat_err_count;
  logic           pkt_done;
  logic           err_valid;
  logic [2:0]     err_code;
  logic [FW-1:0]  err_flow;

  logic en_main;
  logic toggle_mode;
  logic tog_en  = 1'b1;
  int   tog_cnt = 0;
  assign enable = toggle_mode ? tog_en : en_main;

  axis_flow_checker #(
    .DATA_WIDTH (DW), .KEEP_WIDTH (KW), .PKT_BEATS (PB), .FLOW_ID_WIDTH (FW),
    .NUM_FLOWS (NF), .CNT_WIDTH (CW), .BYTE_CNT_WIDTH (BCW)
  ) dut (
    .clk (clk), .rst_n (rst_n),
    .s_axis_tdata (s_axis_tdata), .s_axis_tkeep (s_axis_tkeep),
    .s_axis_tvalid (s_axis_tvalid), .s_axis_tready (s_axis_tready),
    .s_axis_tlast (s_axis_tlast), .enable (enable),
    .stat_flow_sel (stat_flow_sel), .stat_flow_pkts (stat_flow_pkts),
    .stat_total_pkts (stat_total_pkts), .stat_total_bytes (stat_total_bytes),
    .stat_err_count (stat_err_count), .pkt_done (pkt_done),
    .err_valid (err_valid), .err_code (err_code), .err_flow (err_flow)
  );

  always @(negedge clk) begin
    if (toggle_mode) begin
      tog_cnt = tog_cnt + 1;
      if (tog_cnt == 3) begin
        tog_en  = ~tog_en;
        tog_cnt = 0;
      end
    end
  end

  int            mon_done = 0;
  int            mon_errs = 0;
  logic [2:0]    mon_code = 3'd0;
  logic [FW-1:0] mon_flow = '0;
  always @(negedge clk) begin
    if (pkt_done) mon_done = mon_done + 1;
    if (err_valid) begin
      mon_errs = mon_errs + 1;
      mon_code = err_code;
      mon_flow = err_flow;
    end
  end

  int n_checks = 0;
  int n_errs   = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errs++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  function automatic logic [DW-1:0] hdr(input int len, input int flow);
    logic [DW-1:0] h;
    logic [15:0]   l;
    h = '0;
    l = 16'(len);
    h[16*8 +: 8] = l[15:8];
    h[17*8 +: 8] = l[7:0];
    h[35*8 +: FW] = FW'(flow);
    return h;
  endfunction

  task automatic drive_beat(input logic [DW-1:0] d, input logic [KW-1:0] k, input logic l);
    int guard;
    guard = 0;
    @(negedge clk);
    s_axis_tdata  = d;
    s_axis_tkeep  = k;
    s_axis_tlast  = l;
    s_axis_tvalid = 1'b1;
    while (!s_axis_tready && guard < LIMIT) begin
      @(negedge clk);
      guard++;
    end
    if (guard >= LIMIT) check("tready_timeout", 64'(guard), 64'(0));
  endtask

  task automatic idle(input int n);
    @(negedge clk);
    s_axis_tvalid = 1'b0;
    s_axis_tlast  = 1'b0;
    repeat (n) @(negedge clk);
  endtask

  task automatic send_pkt(input int flow, input int base, input int len, input int last_beat,
                          input int bad_beat, input int hole_beat);
    logic [DW-1:0] d;
    logic [KW-1:0] k;
    logic [63:0]   w;
    for (int b = 0; b <= last_beat; b++) begin
      if (b == 0) begin
        d = hdr(len, flow);
      end else begin
        w = 64'(base) + 64'(b);
        if (b == bad_beat) w = w + 64'd1;
        d = DW'(w);
      end
      k = '1;
      if (b == hole_beat) k[0] = 1'b0;
      drive_beat(d, k, b == last_beat);
    end
  endtask

  task automatic read_flow(input int f, output logic [CW-1:0] v);
    @(negedge clk);
    stat_flow_sel = 2'(f);
    @(negedge clk);
    v = stat_flow_pkts;
  endtask

  task automatic err_pkt(input string tag, input int flow, input int base, input int len,
                         input int last_beat, input int bad_beat, input int hole_beat,
                         input int exp_code);
    int e0;
    e0 = mon_errs;
    send_pkt(flow, base, len, last_beat, bad_beat, hole_beat);
    idle(3);
    check({tag, "_npulse"}, 64'(mon_errs - e0), 64'(1));
    check({tag, "_code"}, 64'(mon_code), 64'(exp_code));
    check({tag, "_flow"}, 64'(mon_flow), 64'(flow));
  endtask

  task automatic good_pkt(input string tag, input int flow, input int base);
    int e0;
    int d0;
    e0 = mon_errs;
    d0 = mon_done;
    send_pkt(flow, base, GOOD_LEN, PB - 1, -1, -1);
    idle(3);
    check({tag, "_npulse"}, 64'(mon_errs - e0), 64'(0));
    check({tag, "_done"}, 64'(mon_done - d0), 64'(1));
  endtask

  task automatic clean_run(input string tag);
    int d0;
    int e0;
    logic [CW-1:0] v;
    d0 = mon_done;
    e0 = mon_errs;
    for (int p = 0; p < 20; p++) send_pkt(FLOWS[p % 10], p + 1, GOOD_LEN, PB - 1, -1, -1);
    idle(3);
    check({tag, "_done"}, 64'(mon_done - d0), 64'(20));
    check({tag, "_errpulse"}, 64'(mon_errs - e0), 64'(0));
    check({tag, "_total"}, 64'(stat_total_pkts), 64'(20));
    check({tag, "_bytes"}, stat_total_bytes, 64'(29440));
    check({tag, "_errcnt"}, 64'(stat_err_count), 64'(0));
    for (int f = 0; f < NF; f++) begin
      read_flow(f, v);
      check($sformatf("%s_flow%0d", tag, f), 64'(v), 64'(EXP_FLOW[f]));
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    s_axis_tvalid = 1'b0;
    s_axis_tlast  = 1'b0;
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_tready"}, 64'(s_axis_tready), 64'(0));
    check({tag, "_pkt_done"}, 64'(pkt_done), 64'(0));
    check({tag, "_err_valid"}, 64'(err_valid), 64'(0));
    check({tag, "_err_code"}, 64'(err_code), 64'(0));
    check({tag, "_err_flow"}, 64'(err_flow), 64'(0));
    check({tag, "_total"}, 64'(stat_total_pkts), 64'(0));
    check({tag, "_bytes"}, stat_total_bytes, 64'(0));
    check({tag, "_errcnt"}, 64'(stat_err_count), 64'(0));
    check({tag, "_flowpkts"}, 64'(stat_flow_pkts), 64'(0));
  endtask

  initial begin
    logic [CW-1:0]  v;
    logic [BCW-1:0] b0;
    rst_n         = 1'b0;
    en_main       = 1'b1;
    toggle_mode   = 1'b0;
    s_axis_tvalid = 1'b0;
    s_axis_tlast  = 1'b0;
    s_axis_tdata  = '0;
    s_axis_tkeep  = '0;
    stat_flow_sel = 2'd0;
    repeat (3) @(negedge clk);
    check_zero("rst");
    rst_n = 1'b1;

    clean_run("clean");

    err_pkt("len", 1, 21, 1457, PB - 1, -1, -1, 1);
    check("len_errcnt", 64'(stat_err_count), 64'(1));
    read_flow(1, v);
    check("len_flow1", 64'(v), 64'(10));

    err_pkt("badflow", 5, 21, GOOD_LEN, PB - 1, -1, -1, 6);

    b0 = stat_total_bytes;
    err_pkt("short", 2, 21, GOOD_LEN, 10, -1, -1, 4);
    check("short_bytes", stat_total_bytes - b0, 64'(11 * 64));
    good_pkt("after_short", 0, 21);
    read_flow(0, v);
    check("after_short_flow0", 64'(v), 64'(7));

    b0 = stat_total_bytes;
    err_pkt("long", 0, 22, GOOD_LEN, 25, -1, -1, 5);
    check("long_bytes", stat_total_bytes - b0, 64'(26 * 64));

    err_pkt("data", 1, 22, GOOD_LEN, PB - 1, 7, -1, 3);
    err_pkt("keep", 1, 22, GOOD_LEN, PB - 1, 7, 3, 2);
    check("errs_total", 64'(stat_total_pkts), 64'(27));
    check("errs_errcnt", 64'(stat_err_count), 64'(6));
    read_flow(2, v);
    check("errs_flow2", 64'(v), 64'(4));

    do_reset();
    good_pkt("seq1", 0, 1);
    good_pkt("seq2", 0, 2);
    err_pkt("seq4", 0, 4, GOOD_LEN, PB - 1, -1, -1, 7);
    good_pkt("seq3", 0, 3);
    read_flow(0, v);
    check("seq_flow0", 64'(v), 64'(3));
    check("seq_errcnt", 64'(stat_err_count), 64'(1));

    for (int b = 0; b < 12; b++)
      drive_beat((b == 0) ? hdr(GOOD_LEN, 1) : DW'(64'(10 + b)), '1, 1'b0);
    @(negedge clk);
    s_axis_tvalid = 1'b0;
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    check_zero("midrst");
    rst_n = 1'b1;
    good_pkt("post_rst", 1, 50);
    read_flow(1, v);
    check("post_rst_flow1", 64'(v), 64'(1));
    check("post_rst_errcnt", 64'(stat_err_count), 64'(0));

    do_reset();
    toggle_mode = 1'b1;
    clean_run("bp");
    toggle_mode = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errs);
    $finish;
  end

endmodule
